// File: rtl/stream_demux_pkg.sv
// Shared types for the stream_demux slice: FSM state encoding and select-width helper.
package stream_demux_pkg;

   typedef enum logic [1:0] {IDLE, PKT, DROP} demux_state_t;

   function automatic int sel_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/stream_demux_oreg.sv
// Single-entry valid/ready pipeline register: 1-cycle latency, reloads on the same cycle it drains.
module stream_demux_oreg #(
   parameter int DW = 8
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic [DW-1:0] in_data,
   output logic          out_valid,
   input  logic          out_ready,
   output logic [DW-1:0] out_data
);

   assign in_ready = !out_valid || out_ready;

   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid <= 1'b0;
         out_data  <= '0;
      end else if (in_valid && in_ready) begin
         out_valid <= 1'b1;
         out_data  <= in_data;
      end else if (out_ready) begin
         out_valid <= 1'b0;
      end
   end

endmodule

// File: rtl/stream_demux.sv
// Registered 1-to-N packet demultiplexer; destination locked from first to last beat.
// Optional macro STREAM_DEMUX_ERR_EN drops packets with an out-of-range select and flags err_drop.
module stream_demux
   import stream_demux_pkg::*;
#(
   parameter int N     = 3,
   parameter int W     = 8,
   parameter int SEL_W = sel_width(N)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             s_valid,
   output logic             s_ready,
   input  logic [W-1:0]     s_data,
   input  logic [SEL_W-1:0] s_sel,
   input  logic             s_last,
   output logic [N-1:0]     m_valid,
   input  logic [N-1:0]     m_ready,
   output logic [W-1:0]     m_data,
   output logic             m_last
`ifdef STREAM_DEMUX_ERR_EN
   ,
   output logic             err_drop
`endif
);

   localparam int DW = W + SEL_W + 1;

   demux_state_t     state, state_nxt;
   logic [SEL_W-1:0] dest_q, dest_nxt, route_dest;
   logic [SEL_W-1:0] out_dest;
   logic [DW-1:0]    out_word;
   logic             out_valid, out_ready, reg_in_ready;
   logic             accept, store, sel_bad;
`ifdef STREAM_DEMUX_ERR_EN
   logic             drop_beat;
`endif

   assign {m_last, out_dest, m_data} = out_word;
   assign sel_bad = {1'b0, s_sel} >= (SEL_W+1)'(N);
   assign accept  = s_valid && s_ready;

`ifdef STREAM_DEMUX_ERR_EN
   assign s_ready  = (state == DROP) || reg_in_ready;
   assign err_drop = drop_beat && !rst;
`else
   assign s_ready  = reg_in_ready;
`endif

   // Only the addressed consumer's ready can drain the register.
   always_comb begin
      m_valid   = '0;
      out_ready = 1'b0;
      for (int i = 0; i < N; i++) begin
         if (out_dest == SEL_W'(i)) begin
            m_valid[i] = out_valid;
            out_ready  = m_ready[i];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state  <= IDLE;
         dest_q <= '0;
      end else begin
         state  <= state_nxt;
         dest_q <= dest_nxt;
      end
   end

   // First beats steer by s_sel and lock it for the rest of the packet.
   always_comb begin
      state_nxt  = state;
      dest_nxt   = dest_q;
      route_dest = dest_q;
      store      = 1'b0;
`ifdef STREAM_DEMUX_ERR_EN
      drop_beat  = 1'b0;
`endif
      case (state)
         IDLE: begin
            route_dest = sel_bad ? '0 : s_sel;
`ifdef STREAM_DEMUX_ERR_EN
            if (accept && sel_bad) begin
               drop_beat = 1'b1;
               if (!s_last) state_nxt = DROP;
            end else if (accept) begin
               store = 1'b1;
               if (!s_last) begin
                  dest_nxt  = route_dest;
                  state_nxt = PKT;
               end
            end
`else
            store = accept;
            if (accept && !s_last) begin
               dest_nxt  = route_dest;
               state_nxt = PKT;
            end
`endif
         end
         PKT: begin
            store = accept;
            if (accept && s_last) state_nxt = IDLE;
         end
`ifdef STREAM_DEMUX_ERR_EN
         DROP: begin
            if (accept && s_last) state_nxt = IDLE;
         end
`endif
         default: state_nxt = IDLE;
      endcase
   end

   stream_demux_oreg #(.DW(DW)) u_oreg (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (store),
      .in_ready  (reg_in_ready),
      .in_data   ({s_last, route_dest, s_data}),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_word)
   );

endmodule

// File: tb/tb_stream_demux.sv
// Self-checking bench for stream_demux (N=3, W=8): directed scenarios plus a randomized scoreboard run.
module tb_stream_demux;

   localparam int N = 3;
   localparam int W = 8;
   localparam int SEL_W = 2;

   logic             clk = 1'b0;
   logic             rst = 1'b0;
   logic             s_valid = 1'b0;
   logic             s_ready;
   logic [W-1:0]     s_data = '0;
   logic [SEL_W-1:0] s_sel = '0;
   logic             s_last = 1'b0;
   logic [N-1:0]     m_valid;
   logic [N-1:0]     m_ready = '0;
   logic [W-1:0]     m_data;
   logic             m_last;
`ifdef STREAM_DEMUX_ERR_EN
   logic             err_drop;
`endif

   int check_cnt = 0;
   int error_cnt = 0;

   typedef struct packed {
      logic [7:0] dest;
      logic       last;
      logic [7:0] data;
   } exp_beat_t;

   exp_beat_t exp_q[$];

   stream_demux #(.N(N), .W(W)) dut (
      .clk      (clk),
      .rst      (rst),
      .s_valid  (s_valid),
      .s_ready  (s_ready),
      .s_data   (s_data),
      .s_sel    (s_sel),
      .s_last   (s_last),
      .m_valid  (m_valid),
      .m_ready  (m_ready),
      .m_data   (m_data),
      .m_last   (m_last)
`ifdef STREAM_DEMUX_ERR_EN
      ,
      .err_drop (err_drop)
`endif
   );

   always #5 clk = ~clk;

   task automatic do_reset();
      rst = 1'b1;
      s_valid = 1'b0;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      s_valid = 1'b1;
      s_data = 8'($urandom);
      s_sel = 2'($urandom_range(0, 2));
      s_last = 1'b0;
      m_ready = 3'b111;
      repeat (2) @(negedge clk);
      check_cnt++;
      if (m_valid !== 3'b000) begin error_cnt++; $display("[TB] FAIL reset_m_valid got=%b want=000", m_valid); end
      check_cnt++;
      if (m_data !== 8'h00) begin error_cnt++; $display("[TB] FAIL reset_m_data got=%h want=00", m_data); end
      check_cnt++;
      if (m_last !== 1'b0) begin error_cnt++; $display("[TB] FAIL reset_m_last got=%b want=0", m_last); end
      rst = 1'b0;
      s_valid = 1'b0;
      @(negedge clk);
      check_cnt++;
      if (s_ready !== 1'b1) begin error_cnt++; $display("[TB] FAIL reset_s_ready got=%b want=1", s_ready); end
      check_cnt++;
      if (m_valid !== 3'b000) begin error_cnt++; $display("[TB] FAIL post_reset_m_valid got=%b want=000", m_valid); end
   endtask

   task automatic test_lock();
      logic [7:0] dat [3];
      logic [1:0] sel [3];
      dat[0] = 8'h11; dat[1] = 8'h22; dat[2] = 8'h33;
      sel[0] = 2'd2;  sel[1] = 2'd0;  sel[2] = 2'd0;
      m_ready = 3'b111;
      for (int k = 0; k < 3; k++) begin
         s_valid = 1'b1;
         s_data = dat[k];
         s_sel = sel[k];
         s_last = (k == 2);
         @(negedge clk);
         check_cnt++;
         if (m_valid !== 3'b100) begin error_cnt++; $display("[TB] FAIL lock_valid beat=%0d got=%b want=100", k, m_valid); end
         check_cnt++;
         if (m_data !== dat[k]) begin error_cnt++; $display("[TB] FAIL lock_data beat=%0d got=%h want=%h", k, m_data, dat[k]); end
         check_cnt++;
         if (m_last !== (k == 2)) begin error_cnt++; $display("[TB] FAIL lock_last beat=%0d got=%b want=%b", k, m_last, (k == 2)); end
      end
      s_valid = 1'b0;
      @(negedge clk);
      check_cnt++;
      if (m_valid !== 3'b000) begin error_cnt++; $display("[TB] FAIL lock_idle got=%b want=000", m_valid); end
   endtask

   task automatic test_backpressure();
      int delivered;
      m_ready = 3'b101;
      s_valid = 1'b1;
      s_data = 8'h5A;
      s_sel = 2'd1;
      s_last = 1'b1;
      @(negedge clk);
      s_valid = 1'b0;
      for (int c = 0; c < 5; c++) begin
         check_cnt++;
         if (m_valid !== 3'b010) begin error_cnt++; $display("[TB] FAIL bp_valid cyc=%0d got=%b want=010", c, m_valid); end
         check_cnt++;
         if (m_data !== 8'h5A) begin error_cnt++; $display("[TB] FAIL bp_data cyc=%0d got=%h want=5a", c, m_data); end
         check_cnt++;
         if (s_ready !== 1'b0) begin error_cnt++; $display("[TB] FAIL bp_s_ready cyc=%0d got=%b want=0", c, s_ready); end
         @(negedge clk);
      end
      m_ready = 3'b111;
      delivered = 0;
      for (int c = 0; c < 4; c++) begin
         #1;
         if (m_valid[1] && m_ready[1] && m_data == 8'h5A) delivered++;
         @(negedge clk);
      end
      check_cnt++;
      if (delivered != 1) begin error_cnt++; $display("[TB] FAIL bp_delivered got=%0d want=1", delivered); end
   endtask

   task automatic test_back_to_back();
      m_ready = 3'b111;
      for (int i = 0; i < 9; i++) begin
         s_valid = 1'b1;
         s_data = 8'(i);
         s_sel = 2'(i % 3);
         s_last = 1'b1;
         @(negedge clk);
         check_cnt++;
         if (m_valid !== 3'(1 << (i % 3))) begin error_cnt++; $display("[TB] FAIL b2b_valid i=%0d got=%b want=%b", i, m_valid, 3'(1 << (i % 3))); end
         check_cnt++;
         if (m_data !== 8'(i)) begin error_cnt++; $display("[TB] FAIL b2b_data i=%0d got=%h want=%h", i, m_data, 8'(i)); end
         check_cnt++;
         if (s_ready !== 1'b1) begin error_cnt++; $display("[TB] FAIL b2b_s_ready i=%0d got=%b want=1", i, s_ready); end
      end
      s_valid = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_mid_reset();
      m_ready = 3'b111;
      s_valid = 1'b1; s_data = 8'h61; s_sel = 2'd1; s_last = 1'b0;
      @(negedge clk);
      s_data = 8'h62; s_sel = 2'd0;
      @(negedge clk);
      s_valid = 1'b0;
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check_cnt++;
      if (m_valid !== 3'b000) begin error_cnt++; $display("[TB] FAIL midrst_cleared got=%b want=000", m_valid); end
      s_valid = 1'b1; s_data = 8'h77; s_sel = 2'd0; s_last = 1'b1;
      @(negedge clk);
      s_valid = 1'b0;
      check_cnt++;
      if (m_valid !== 3'b001) begin error_cnt++; $display("[TB] FAIL midrst_valid got=%b want=001", m_valid); end
      check_cnt++;
      if (m_data !== 8'h77) begin error_cnt++; $display("[TB] FAIL midrst_data got=%h want=77", m_data); end
      @(negedge clk);
   endtask

   task automatic test_bad_select();
      logic [7:0] dat [3];
      logic [1:0] sel [3];
      logic       lst [3];
      logic [2:0] mv  [3];
      logic [7:0] md  [3];
      int         pulses;
      dat[0] = 8'hA1; sel[0] = 2'd3; lst[0] = 1'b0;
      dat[1] = 8'hA2; sel[1] = 2'd0; lst[1] = 1'b1;
      dat[2] = 8'h44; sel[2] = 2'd1; lst[2] = 1'b1;
      pulses = 0;
      m_ready = 3'b111;
      for (int k = 0; k < 3; k++) begin
         s_valid = 1'b1; s_data = dat[k]; s_sel = sel[k]; s_last = lst[k];
         #1;
`ifdef STREAM_DEMUX_ERR_EN
         if (err_drop === 1'b1) pulses++;
`endif
         @(negedge clk);
         mv[k] = m_valid;
         md[k] = m_data;
      end
      s_valid = 1'b0;
      #1;
`ifdef STREAM_DEMUX_ERR_EN
      if (err_drop === 1'b1) pulses++;
      check_cnt++;
      if (pulses != 1) begin error_cnt++; $display("[TB] FAIL drop_pulses got=%0d want=1", pulses); end
      check_cnt++;
      if (mv[0] !== 3'b000) begin error_cnt++; $display("[TB] FAIL drop_beat0 got=%b want=000", mv[0]); end
      check_cnt++;
      if (mv[1] !== 3'b000) begin error_cnt++; $display("[TB] FAIL drop_beat1 got=%b want=000", mv[1]); end
`else
      check_cnt++;
      if (mv[0] !== 3'b001 || md[0] !== 8'hA1) begin error_cnt++; $display("[TB] FAIL badsel_beat0 got=%b/%h want=001/a1", mv[0], md[0]); end
      check_cnt++;
      if (mv[1] !== 3'b001 || md[1] !== 8'hA2) begin error_cnt++; $display("[TB] FAIL badsel_beat1 got=%b/%h want=001/a2", mv[1], md[1]); end
`endif
      check_cnt++;
      if (mv[2] !== 3'b010 || md[2] !== 8'h44) begin error_cnt++; $display("[TB] FAIL badsel_next got=%b/%h want=010/44", mv[2], md[2]); end
      @(negedge clk);
   endtask

   // Packet-level reference: each packet goes to the select of its first beat.
   task automatic test_random();
      bit        first, dropping, fired, exp_drop;
      int        lock_dest, idx, d;
      exp_beat_t e;
      exp_q.delete();
      do_reset();
      first = 1'b1;
      dropping = 1'b0;
      lock_dest = 0;
      fired = 1'b0;
      for (int cyc = 0; cyc < 640; cyc++) begin
         if (fired) s_valid = 1'b0;
         if (cyc < 600) begin
            if (!s_valid && ($urandom % 4 != 0)) begin
               s_valid = 1'b1;
               s_data = 8'($urandom);
               s_sel = 2'($urandom_range(0, 3));
               s_last = ($urandom % 3 == 0);
            end
            m_ready = 3'($urandom);
         end else begin
            m_ready = 3'b111;
         end
         #1;
         check_cnt++;
         if ($countones(m_valid) > 1) begin error_cnt++; $display("[TB] FAIL rnd_onehot cyc=%0d got=%b", cyc, m_valid); end
         if (m_valid != 3'b000) begin
            idx = (m_valid[0]) ? 0 : (m_valid[1]) ? 1 : 2;
            if (m_ready[idx]) begin
               check_cnt++;
               if (exp_q.size() == 0) begin
                  error_cnt++;
                  $display("[TB] FAIL rnd_extra cyc=%0d got dest=%0d data=%h want=none", cyc, idx, m_data);
               end else begin
                  e = exp_q.pop_front();
                  if (idx != int'(e.dest) || m_data !== e.data || m_last !== e.last) begin
                     error_cnt++;
                     $display("[TB] FAIL rnd_beat cyc=%0d got=%0d/%h/%b want=%0d/%h/%b",
                              cyc, idx, m_data, m_last, e.dest, e.data, e.last);
                  end
               end
            end
         end
         fired = s_valid && s_ready;
         exp_drop = 1'b0;
         if (fired) begin
            if (dropping) begin
               if (s_last) dropping = 1'b0;
            end else begin
               d = first ? int'(s_sel) : lock_dest;
`ifdef STREAM_DEMUX_ERR_EN
               if (first && d >= N) begin
                  exp_drop = 1'b1;
                  if (!s_last) dropping = 1'b1;
               end else begin
                  e.dest = 8'(d); e.last = s_last; e.data = s_data;
                  exp_q.push_back(e);
                  lock_dest = d;
                  first = s_last;
               end
`else
               if (d >= N) d = 0;
               e.dest = 8'(d); e.last = s_last; e.data = s_data;
               exp_q.push_back(e);
               lock_dest = d;
               first = s_last;
`endif
            end
         end
`ifdef STREAM_DEMUX_ERR_EN
         check_cnt++;
         if (err_drop !== exp_drop) begin error_cnt++; $display("[TB] FAIL rnd_err_drop cyc=%0d got=%b want=%b", cyc, err_drop, exp_drop); end
`endif
         @(negedge clk);
      end
      check_cnt++;
      if (exp_q.size() != 0) begin error_cnt++; $display("[TB] FAIL rnd_drain got=%0d pending want=0", exp_q.size()); end
   endtask

   initial begin
      @(negedge clk);
      test_reset();
      test_lock();
      test_backpressure();
      test_back_to_back();
      test_mid_reset();
      test_bad_select();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", check_cnt, error_cnt);
      $finish;
   end

endmodule
